// File: rtl/ocr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ocr_pkg
// Purpose  : Shared definitions for the OCR frame sequencer: sequencer state
//            encoding (exported on the debug port), frame geometry, the host
//            start command and the result byte format.
// Revision : 1.0  initial release
// ============================================================================
package ocr_pkg;

  localparam int         c_IMG_BYTES   = 113;    // 900 bits, last byte low nibble
  localparam int         c_ACK_TIMEOUT = 16;     // cycles allowed for write ack
  localparam logic [7:0] c_CMD_START   = 8'hA5;  // host byte that begins a frame

  // Explicit encodings: these values are visible to the host on state_dbg.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RECV  = 3'd2,
    ST_WRITE = 3'd3,
    ST_GAP   = 3'd4,
    ST_INFER = 3'd5,
    ST_SEND  = 3'd6,
    ST_ERR   = 3'd7
  } ocr_state_e;

  // Result byte returned to the host: upper nibble zero, class in low nibble.
  typedef struct packed {
    logic [3:0] pad;
    logic [3:0] cls;
  } result_byte_t;

  function automatic logic [7:0] make_result_byte(input logic [3:0] cls);
    result_byte_t r;
    r.pad = 4'h0;
    r.cls = cls;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ocr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ocr_sequencer
// Purpose  : Frame sequencer between the host byte receiver and the image
//            buffer / BNN inference core. A start command clears the buffer,
//            IMG_BYTES data bytes are written with a request/ack handshake,
//            one inference is launched and the class is returned as one byte.
// Ports    : clk, rst_n            clock, synchronous active-low reset
//            i_rx_byte/i_rx_valid  host receive stream
//            o_buf_*/i_buf_*       image buffer clear/write port and status
//            o_infer_start, i_infer_done, i_infer_result  inference core
//            o_tx_byte/o_tx_valid/i_tx_ready  host transmit handshake
//            o_busy, o_error, o_state_dbg     status
// Revision : 1.0  initial release
// ============================================================================
module ocr_sequencer
  import ocr_pkg::*;
#(
  parameter int         IMG_BYTES   = c_IMG_BYTES,
  parameter int         ACK_TIMEOUT = c_ACK_TIMEOUT,
  parameter logic [7:0] CMD_START   = c_CMD_START
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_rx_byte,
  input  logic       i_rx_valid,
  output logic       o_buf_clear,
  output logic [7:0] o_buf_data,
  output logic       o_buf_write_request,
  input  logic       i_buf_write_ready,
  input  logic       i_buf_write_ack,
  input  logic       i_buf_full,
  output logic       o_infer_start,
  input  logic       i_infer_done,
  input  logic [3:0] i_infer_result,
  output logic [7:0] o_tx_byte,
  output logic       o_tx_valid,
  input  logic       i_tx_ready,
  output logic       o_busy,
  output logic       o_error,
  output logic [2:0] o_state_dbg
);

  localparam logic [6:0] c_CNT_LAST = 7'(IMG_BYTES);
  localparam logic [4:0] c_TMO_LAST = 5'(ACK_TIMEOUT - 1);

  ocr_state_e r_state;
  ocr_state_e w_next_state;

  logic [6:0] r_byte_cnt;
  logic [6:0] w_byte_cnt_next;
  logic [6:0] w_cnt_inc;
  logic [4:0] r_tmo_cnt;
  logic [4:0] w_tmo_next;
  logic       r_recv_first;   // first cycle of a RECV visit
  logic       w_overrun;
  logic       w_is_cmd;

  logic       r_buf_clear;
  logic [7:0] r_buf_data;
  logic       r_buf_req;
  logic       r_infer_start;
  logic [7:0] r_tx_byte;
  logic       r_tx_valid;
  logic       r_busy;
  logic       r_error;

  assign w_is_cmd  = i_rx_valid && (i_rx_byte == CMD_START);
  assign w_cnt_inc = r_byte_cnt + 7'd1;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and counter logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state    = r_state;
    w_byte_cnt_next = r_byte_cnt;
    w_tmo_next      = r_tmo_cnt;
    w_overrun       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_is_cmd) w_next_state = ST_CLEAR;
      end
      ST_CLEAR: begin
        w_byte_cnt_next = 7'd0;
        w_next_state    = ST_RECV;
      end
      ST_RECV: begin
        // A start command byte here is image data, not a command.
        if (r_recv_first && !i_buf_write_ready) begin
          w_next_state = ST_ERR;
        end else if (i_rx_valid) begin
          w_tmo_next   = 5'd0;
          w_next_state = ST_WRITE;
        end
      end
      ST_WRITE: begin
        w_overrun = i_rx_valid;
        if (i_buf_write_ack) begin
          w_next_state = ST_GAP;
        end else if (r_tmo_cnt == c_TMO_LAST) begin
          w_next_state = ST_ERR;
        end else begin
          w_tmo_next = r_tmo_cnt + 5'd1;
        end
      end
      ST_GAP: begin
        // Request is low here so the buffer sees a fresh rising edge next time.
        w_overrun       = i_rx_valid;
        w_byte_cnt_next = w_cnt_inc;
        if (w_cnt_inc == c_CNT_LAST) begin
          // The buffer must report full before an inference is launched;
          // checking here keeps infer_start from ever pulsing on a bad frame.
          w_next_state = i_buf_full ? ST_INFER : ST_ERR;
        end else begin
          w_next_state = ST_RECV;
        end
      end
      ST_INFER: begin
        w_overrun = i_rx_valid;
        if (i_infer_done) w_next_state = ST_SEND;
      end
      ST_SEND: begin
        w_overrun = i_rx_valid;
        if (i_tx_ready) w_next_state = ST_IDLE;
      end
      ST_ERR: begin
        if (w_is_cmd) w_next_state = ST_CLEAR;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registered datapath and outputs (all decoded from the next state so that
  // every output changes on the cycle after its cause)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_byte_cnt    <= 7'd0;
      r_tmo_cnt     <= 5'd0;
      r_recv_first  <= 1'b0;
      r_buf_clear   <= 1'b0;
      r_buf_data    <= 8'h00;
      r_buf_req     <= 1'b0;
      r_infer_start <= 1'b0;
      r_tx_byte     <= 8'h00;
      r_tx_valid    <= 1'b0;
      r_busy        <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_byte_cnt    <= w_byte_cnt_next;
      r_tmo_cnt     <= w_tmo_next;
      r_recv_first  <= (w_next_state == ST_RECV) && (r_state != ST_RECV);
      r_buf_clear   <= (w_next_state == ST_CLEAR);
      r_buf_req     <= (w_next_state == ST_WRITE);
      r_infer_start <= (w_next_state == ST_INFER) && (r_state != ST_INFER);
      r_tx_valid    <= (w_next_state == ST_SEND);
      r_busy        <= (w_next_state != ST_IDLE);

      if ((r_state == ST_RECV) && (w_next_state == ST_WRITE)) begin
        r_buf_data <= i_rx_byte;
      end
      if ((r_state == ST_INFER) && i_infer_done) begin
        r_tx_byte <= make_result_byte(i_infer_result);
      end

      // Sticky until the next frame start clears it.
      if (w_next_state == ST_CLEAR) begin
        r_error <= 1'b0;
      end else if ((w_next_state == ST_ERR) || w_overrun) begin
        r_error <= 1'b1;
      end
    end
  end

  assign o_buf_clear         = r_buf_clear;
  assign o_buf_data          = r_buf_data;
  assign o_buf_write_request = r_buf_req;
  assign o_infer_start       = r_infer_start;
  assign o_tx_byte           = r_tx_byte;
  assign o_tx_valid          = r_tx_valid;
  assign o_busy              = r_busy;
  assign o_error             = r_error;
  assign o_state_dbg         = r_state;

endmodule
`default_nettype wire

// File: doc/ocr_sequencer.md
# ocr_sequencer

Top-level sequencer between the host byte receiver and the image buffer / BNN inference core. It decodes a start command, clears the image buffer, and streams 113 image bytes into it with a request/ack handshake. It then launches one inference and returns the 4-bit class result as a single byte to the host transmitter. It is the only master of the image buffer's clear and write ports.

## Interface
- IMG_BYTES, 113, image bytes per frame (900 bits, last byte uses low nibble)
- ACK_TIMEOUT, 16, cycles allowed for buf_write_ack after request rises
- CMD_START, 8'hA5, host command byte that begins a frame
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- rx_byte  in  8  received host byte
- rx_valid  in  1  one-cycle strobe, rx_byte valid
- buf_clear  out  1  one-cycle clear pulse to image buffer
- buf_data  out  8  byte to write
- buf_write_request  out  1  write request (buffer is rising-edge sensitive)
- buf_write_ready  in  1  buffer can accept a byte
- buf_write_ack  in  1  registered ack from buffer
- buf_full  in  1  buffer holds all IMG_BYTES
- infer_start  out  1  one-cycle inference launch
- infer_done  in  1  one-cycle completion strobe
- infer_result  in  4  class index, valid with infer_done
- tx_byte  out  8  result byte {4'h0, class}
- tx_valid  out  1  held until tx_ready
- tx_ready  in  1  transmitter accepts tx_byte
- busy  out  1  state != IDLE
- error  out  1  sticky fault flag
- state_dbg  out  3  current state encoding

## Operation
- States: IDLE, CLEAR, RECV, WRITE, GAP, INFER, SEND, ERR.
- IDLE: rx_valid with rx_byte==CMD_START -> CLEAR; other bytes ignored.
- CLEAR: buf_clear=1 for exactly one cycle, byte_cnt<=0, error<=0 -> RECV.
- RECV: on rx_valid, latch rx_byte into buf_data -> WRITE. If buf_write_ready==0 on entry -> ERR.
- WRITE: buf_write_request=1. On buf_write_ack -> GAP. If ACK_TIMEOUT cycles elapse with no ack -> ERR.
- GAP: request low for one cycle, guaranteeing a fresh rising edge. byte_cnt+1. If new count==IMG_BYTES -> INFER, else -> RECV.
- INFER: pulse infer_start on the entry cycle only. Require buf_full==1 on entry, else -> ERR. Wait for infer_done; latch infer_result -> SEND.
- SEND: tx_valid=1, tx_byte={4'h0,result} stable until tx_ready -> IDLE.
- ERR: error=1 (sticky). Only rx_byte==CMD_START exits -> CLEAR, which clears error.
- Overrun: rx_valid in WRITE/GAP/INFER/SEND -> byte dropped, error<=1, state unaffected.
- byte_cnt is 7 bits and never exceeds IMG_BYTES. The timeout counter is 5 bits, reset on WRITE entry.
- CMD_START received in RECV is treated as image data, not as a command.

## Timing
- Reset (rst_n low at a clk edge): state IDLE. Outputs buf_clear, buf_write_request, infer_start, tx_valid, busy and error are 0. buf_data, tx_byte and state_dbg are 0. Counters are 0.
- Reset asserted mid-frame aborts immediately. The buffer is not cleared until the next CMD_START.
- All outputs are registered and change on the cycle after the causing input.
- Per byte (ack one cycle after request rises):
  - rx_valid at cycle N
  - request high at N+1
  - ack seen at N+2
  - GAP at N+3
  - RECV at N+4
- Minimum rx_valid spacing is 4 cycles. Closer spacing is an overrun.
- Command to first accepted data byte: CLEAR occupies 1 cycle, so RECV is active 2 cycles after the CMD_START strobe.
- infer_done arriving on the same cycle infer_start is raised is accepted.
- tx_ready already high on SEND entry: handshake completes in 1 cycle, and the next cycle is IDLE.

## Structure
- Shared package ocr_pkg holds:
  - state enum (3-bit, explicit encodings, exported on state_dbg)
  - CMD_START
  - IMG_BYTES
  - result byte format
- No sub-module. The ack timeout counter is inline.

## Test plan
- Reset, then CMD_START followed by 113 bytes spaced 10 cycles, with a buffer model acking after 1 cycle, then infer_done with result 4'h7 -> one buf_clear pulse, 113 request edges, one infer_start, tx_byte=8'h07, busy falls after tx_ready.
- Buffer model never acks the byte-5 write -> ERR after 16 cycles, error=1. A new CMD_START clears error and restarts at byte_cnt 0.
- Two rx_valid 2 cycles apart during a frame -> second byte dropped, error=1, buffer still receives exactly one write for the first byte.
- buf_full forced 0 when the 113th byte completes -> ERR, no infer_start.
- rst_n low at byte 60 -> all outputs 0 on the next cycle, IDLE. A full frame afterward completes normally.
- Bytes other than 8'hA5 in IDLE -> no state change, no buf_clear.
